// File: rtl/parking_controller.sv
// rtl/parking_controller.sv - parking entrance gate controller with PIN check, attempt limit and block alarm.
// Optional WAIT_PIN idle timeout is enabled by defining PARKING_TIMEOUT_EN.
module parking_controller #(
    parameter logic [15:0] PIN            = 16'h5990,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          CNT_W          = 8,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vehicle_arrival,
    input  logic             vehicle_left,
    input  logic [15:0]      code,
    input  logic             code_ack,
    output logic             gate_open,
    output logic             gate_closed,
    output logic             wrong_pin_alarm,
    output logic             block_alarm,
    output logic [CNT_W-1:0] admitted_cnt
);

    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

    if (MAX_ATTEMPTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("parking_controller: MAX_ATTEMPTS and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT_PIN, GATE_OPEN, BLOCKED} state_t;

    state_t             state;
    logic               ack_q;
    logic               arr_q;
    logic [ATT_W-1:0]   attempts;
    logic               ack_rise;
    logic               pin_ok;
    logic               arr_rise;

`ifdef PARKING_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_cnt;
`endif

    assign ack_rise = code_ack & ~ack_q;
    assign pin_ok   = ack_rise && (code == PIN);
    assign arr_rise = vehicle_arrival & ~arr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ack_q           <= 1'b0;
            arr_q           <= 1'b0;
            attempts        <= '0;
            gate_open       <= 1'b0;
            gate_closed     <= 1'b1;
            wrong_pin_alarm <= 1'b0;
            block_alarm     <= 1'b0;
            admitted_cnt    <= '0;
`ifdef PARKING_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            ack_q <= code_ack;
            arr_q <= vehicle_arrival;
            case (state)
                IDLE: begin
                    if (vehicle_arrival) begin
                        state <= WAIT_PIN;
`ifdef PARKING_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                WAIT_PIN: begin
                    if (ack_rise) begin
`ifdef PARKING_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (code == PIN) begin
                            state           <= GATE_OPEN;
                            gate_open       <= 1'b1;
                            gate_closed     <= 1'b0;
                            attempts        <= '0;
                            wrong_pin_alarm <= 1'b0;
                            if (admitted_cnt != '1)
                                admitted_cnt <= admitted_cnt + 1'b1;
                        end else if (attempts != ATT_W'(MAX_ATTEMPTS)) begin
                            // Attempts saturate at the limit so the alarm never wraps away
                            attempts <= attempts + 1'b1;
                            if (attempts == ATT_W'(MAX_ATTEMPTS - 1))
                                wrong_pin_alarm <= 1'b1;
                        end
                    end else if (!vehicle_arrival) begin
                        state <= IDLE;
                    end
`ifdef PARKING_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                GATE_OPEN: begin
                    // A new arrival takes priority over the departing vehicle
                    if (arr_rise) begin
                        state       <= BLOCKED;
                        block_alarm <= 1'b1;
                        gate_open   <= 1'b0;
                        gate_closed <= 1'b1;
                    end else if (vehicle_left) begin
                        state       <= IDLE;
                        gate_open   <= 1'b0;
                        gate_closed <= 1'b1;
                    end
                end
                BLOCKED: begin
                    if (pin_ok) begin
                        state           <= IDLE;
                        block_alarm     <= 1'b0;
                        attempts        <= '0;
                        wrong_pin_alarm <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
